// File: rtl/input_cond_pkg.sv
// Shared widths, idle levels and default debounce length for the input conditioner.
package input_cond_pkg;

    localparam int SWIT_W                  = 3;
    localparam int BUTT_W                  = 2;
    localparam logic [SWIT_W-1:0] SWIT_IDLE = 3'b000;
    localparam logic [BUTT_W-1:0] BUTT_IDLE = 2'b11;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: synchroniser chain, hold counter and accepted level, with
// registered edge pulses aligned to the cycle the level changes.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 19,
    parameter int   SYNC_STAGES     = 2,
    parameter logic IDLE            = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        // Any cycle where synced matches the accepted level restarts the count.
        if (synced != stable_q) begin
            if (cnt_q == LIMIT) begin
                stable_d = synced;
                rise_d   = synced;
                fall_d   = ~synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= {SYNC_STAGES{IDLE}};
            cnt_q    <= '0;
            stable_q <= IDLE;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces board switches and active-low buttons.
// Define INPUT_CONDITIONER_RELEASE_PULSE_EN to add the butt_release pulse output.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 19,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SWIT_W-1:0] raw_swit,
    input  logic [BUTT_W-1:0] raw_butt,
    output logic [SWIT_W-1:0] swit,
    output logic [BUTT_W-1:0] butt,
    output logic [BUTT_W-1:0] butt_press
`ifdef INPUT_CONDITIONER_RELEASE_PULSE_EN
    ,
    output logic [BUTT_W-1:0] butt_release
`endif
);

    logic [SWIT_W-1:0] swit_rise_unused;
    logic [SWIT_W-1:0] swit_fall_unused;
    logic [BUTT_W-1:0] butt_rise;

    for (genvar i = 0; i < SWIT_W; i++) begin : g_swit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES),
            .IDLE            (SWIT_IDLE[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_swit[i]),
            .level (swit[i]),
            .rise  (swit_rise_unused[i]),
            .fall  (swit_fall_unused[i])
        );
    end

    // Buttons idle high, so a press is the accepted falling edge.
    for (genvar i = 0; i < BUTT_W; i++) begin : g_butt
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_STAGES     (SYNC_STAGES),
            .IDLE            (BUTT_IDLE[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_butt[i]),
            .level (butt[i]),
            .rise  (butt_rise[i]),
            .fall  (butt_press[i])
        );
    end

`ifdef INPUT_CONDITIONER_RELEASE_PULSE_EN
    assign butt_release = butt_rise;
`else
    logic [BUTT_W-1:0] butt_rise_unused;
    assign butt_rise_unused = butt_rise;
`endif

endmodule
